// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
// Queues architectural commit events (GRF writes from W, DM writes from M) in
// program order for a downstream consumer. The core is never stalled: events
// that find no free slot are dropped and counted.

module commit_trace_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       grf_we,
    input  logic [31:0]                grf_pc,
    input  logic [4:0]                 grf_addr,
    input  logic [31:0]                grf_wd,
    input  logic                       dm_we,
    input  logic [31:0]                dm_pc,
    input  logic [31:0]                dm_addr,
    input  logic [31:0]                dm_wd,
    output logic                       tr_valid,
    input  logic                       tr_ready,
    output logic                       tr_type,
    output logic [31:0]                tr_pc,
    output logic [31:0]                tr_addr,
    output logic [31:0]                tr_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 97;
    localparam logic [LW:0] FREE_FULL = (LW + 1)'(DEPTH);
    localparam logic [LW:0] FREE_ONE  = (LW + 1)'(1);
    localparam logic [LW:0] FREE_TWO  = (LW + 1)'(2);

    // Entry layout: {type, pc, addr, data}
    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic          grf_ev, dm_ev, pop;
    logic [LW:0]   free_slots;
    logic [1:0]    n_push, n_drop;
    logic          wr0_en, wr1_en;
    logic [AW-1:0] wr1_ptr;
    logic [EW-1:0] grf_entry, dm_entry, wr0_entry, wr1_entry;
    logic [16:0]   drop_sum;
    logic [EW-1:0] head;

    assign tr_valid = (level_q != '0);
    assign head     = mem_q[rd_ptr_q];
    assign tr_type  = head[96];
    assign tr_pc    = head[95:64];
    assign tr_addr  = head[63:32];
    assign tr_data  = head[31:0];
    assign level    = level_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    // Admission: GRF (older) claims a slot before DM; a pop frees a slot this cycle.
    always_comb begin
        grf_ev     = grf_we && (grf_addr != 5'd0);
        dm_ev      = dm_we;
        pop        = tr_valid && tr_ready;
        free_slots = FREE_FULL - {1'b0, level_q} + {{LW{1'b0}}, pop};
        grf_entry  = {1'b0, grf_pc, {27'b0, grf_addr}, grf_wd};
        dm_entry   = {1'b1, dm_pc, dm_addr, dm_wd};
        n_push     = 2'd0;
        n_drop     = 2'd0;
        wr0_en     = 1'b0;
        wr1_en     = 1'b0;
        wr0_entry  = grf_entry;
        wr1_entry  = dm_entry;
        wr1_ptr    = wr_ptr_q + AW'(1);

        if (grf_ev && dm_ev) begin
            if (free_slots >= FREE_TWO) begin
                n_push = 2'd2;
                wr0_en = 1'b1;
                wr1_en = 1'b1;
            end else if (free_slots == FREE_ONE) begin
                n_push = 2'd1;
                n_drop = 2'd1;
                wr0_en = 1'b1;
            end else begin
                n_drop = 2'd2;
            end
        end else if (grf_ev || dm_ev) begin
            wr0_entry = grf_ev ? grf_entry : dm_entry;
            if (free_slots != '0) begin
                n_push = 2'd1;
                wr0_en = 1'b1;
            end else begin
                n_drop = 2'd1;
            end
        end

        wr_ptr_d   = wr_ptr_q + AW'(n_push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        level_d    = level_q + LW'(n_push) - LW'(pop);
        drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d = overflow_q | (n_drop != 2'd0);
    end

    // Pointer, occupancy and drop-statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage: up to two adjacent slots written per cycle, contents not reset.
    always_ff @(posedge clk) begin
        if (wr0_en) mem_q[wr_ptr_q] <= wr0_entry;
        if (wr1_en) mem_q[wr1_ptr]  <= wr1_entry;
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer
// Self-checking bench: a queue-based reference model is compared with the DUT
// every cycle, and directed scenarios pin the model with literal expectations.

module tb_commit_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        grf_we = 1'b0;
    logic [31:0] grf_pc = '0;
    logic [4:0]  grf_addr = '0;
    logic [31:0] grf_wd = '0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_pc = '0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wd = '0;
    logic        tr_ready = 1'b0;
    logic        tr_valid;
    logic        tr_type;
    logic [31:0] tr_pc;
    logic [31:0] tr_addr;
    logic [31:0] tr_data;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;

    int comparedCount = 0;
    int mismatchCount = 0;
    bit checkOn = 1'b0;

    typedef struct packed {
        logic        t;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t  mq[$];
    logic mOverflow = 1'b0;
    int   mDrops = 0;

    commit_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wd(grf_wd),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_type(tr_type),
        .tr_pc(tr_pc), .tr_addr(tr_addr), .tr_data(tr_data),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        comparedCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle of the reference model: pop first, then admit events oldest-first.
    task automatic modelStep();
        int  free;
        int  drops;
        bit  doPop;
        ev_t e;
        doPop = (mq.size() != 0) && tr_ready;
        free  = DEPTH - mq.size() + (doPop ? 1 : 0);
        if (doPop) void'(mq.pop_front());
        drops = 0;
        if (grf_we && grf_addr != 5'd0) begin
            if (free > 0) begin
                e = '{t: 1'b0, pc: grf_pc, addr: {27'b0, grf_addr}, data: grf_wd};
                mq.push_back(e);
                free--;
            end else drops++;
        end
        if (dm_we) begin
            if (free > 0) begin
                e = '{t: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_wd};
                mq.push_back(e);
                free--;
            end else drops++;
        end
        mDrops = (mDrops + drops > 65535) ? 65535 : mDrops + drops;
        if (drops > 0) mOverflow = 1'b1;
    endtask

    // Reference model advances on each active edge and clears on reset.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mq.delete();
                mOverflow = 1'b0;
                mDrops    = 0;
            end else begin
                modelStep();
            end
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && checkOn) begin
                checkOutput("tr_valid", 32'(tr_valid), 32'(mq.size() != 0));
                checkOutput("level", 32'(level), 32'(mq.size()));
                checkOutput("overflow", 32'(overflow), 32'(mOverflow));
                checkOutput("drop_cnt", 32'(drop_cnt), 32'(mDrops));
                if (mq.size() != 0) begin
                    checkOutput("tr_type", 32'(tr_type), 32'(mq[0].t));
                    checkOutput("tr_pc", tr_pc, mq[0].pc);
                    checkOutput("tr_addr", tr_addr, mq[0].addr);
                    checkOutput("tr_data", tr_data, mq[0].data);
                end
            end
        end
    end

    // Drive one cycle of inputs, then return at the following falling edge.
    task automatic applyStimulus(input logic gWe, input logic [31:0] gPc,
                                 input logic [4:0] gAddr, input logic [31:0] gWd,
                                 input logic dWe, input logic [31:0] dPc,
                                 input logic [31:0] dAddr, input logic [31:0] dWd,
                                 input logic ready);
        grf_we = gWe; grf_pc = gPc; grf_addr = gAddr; grf_wd = gWd;
        dm_we = dWe; dm_pc = dPc; dm_addr = dAddr; dm_wd = dWd;
        tr_ready = ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n, input logic ready);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, ready);
    endtask

    task automatic grfEvent(input logic [31:0] pc, input logic [4:0] addr,
                            input logic [31:0] wd, input logic ready);
        applyStimulus(1'b1, pc, addr, wd, 1'b0, '0, '0, '0, ready);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset state
        #12;
        checkOutput("rst_valid", 32'(tr_valid), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        checkOn = 1'b1;
        idleCycles(1, 1'b0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_drop", 32'(drop_cnt), 32'd0);

        // Single event with a fast consumer
        grfEvent(32'h3000, 5'd8, 32'h1234, 1'b1);
        checkOutput("single_valid", 32'(tr_valid), 32'd1);
        checkOutput("single_type", 32'(tr_type), 32'd0);
        checkOutput("single_addr", tr_addr, 32'd8);
        checkOutput("single_data", tr_data, 32'h1234);
        idleCycles(1, 1'b1);
        checkOutput("single_drained", 32'(tr_valid), 32'd0);
        checkOutput("single_level", 32'(level), 32'd0);

        // Register $0 writes are filtered
        grfEvent(32'h3004, 5'd0, 32'hDEAD, 1'b0);
        checkOutput("zero_level", 32'(level), 32'd0);
        checkOutput("zero_drop", 32'(drop_cnt), 32'd0);

        // Same-cycle pair keeps GRF before DM
        applyStimulus(1'b1, 32'h3008, 5'd3, 32'h55, 1'b1, 32'h300c, 32'h10, 32'hAB, 1'b0);
        checkOutput("pair_level", 32'(level), 32'd2);
        checkOutput("pair_first_type", 32'(tr_type), 32'd0);
        checkOutput("pair_first_pc", tr_pc, 32'h3008);
        idleCycles(1, 1'b1);
        checkOutput("pair_second_type", 32'(tr_type), 32'd1);
        checkOutput("pair_second_pc", tr_pc, 32'h300c);
        checkOutput("pair_second_addr", tr_addr, 32'h10);
        idleCycles(1, 1'b1);
        checkOutput("pair_empty", 32'(level), 32'd0);

        // Fill to DEPTH plus one; the extra event is dropped
        for (int i = 0; i < 17; i++)
            grfEvent(32'h4000 + 32'(4 * i), 5'((i % 31) + 1), 32'h1000 + 32'(i), 1'b0);
        checkOutput("fill_level", 32'(level), 32'd16);
        checkOutput("fill_overflow", 32'(overflow), 32'd1);
        checkOutput("fill_drop", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 16; i++) begin
            checkOutput("drain_pc", tr_pc, 32'h4000 + 32'(4 * i));
            idleCycles(1, 1'b1);
        end
        checkOutput("drain_empty", 32'(tr_valid), 32'd0);

        // level 15 then a pair: GRF admitted, DM dropped
        for (int i = 0; i < 15; i++)
            grfEvent(32'h5000 + 32'(4 * i), 5'd9, 32'(i), 1'b0);
        applyStimulus(1'b1, 32'h503c, 5'd4, 32'h77, 1'b1, 32'h5040, 32'h20, 32'h88, 1'b0);
        checkOutput("b15_level", 32'(level), 32'd16);
        checkOutput("b15_drop", 32'(drop_cnt), 32'd2);

        // Full queue: pop and push in the same cycle, no drop
        grfEvent(32'h5044, 5'd5, 32'h99, 1'b1);
        checkOutput("b16_level", 32'(level), 32'd16);
        checkOutput("b16_drop", 32'(drop_cnt), 32'd2);
        checkOutput("b16_head_pc", tr_pc, 32'h5004);
        idleCycles(16, 1'b1);
        checkOutput("b16_empty", 32'(level), 32'd0);

        // Reset asserted mid-drain between edges
        for (int i = 0; i < 5; i++)
            grfEvent(32'h6000 + 32'(4 * i), 5'd6, 32'(i), 1'b0);
        checkOutput("mid_level", 32'(level), 32'd5);
        tr_ready = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_valid", 32'(tr_valid), 32'd0);
        checkOutput("async_level", 32'(level), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tr_ready = 1'b0;
        #1;
        checkOutput("post_level", 32'(level), 32'd0);
        checkOutput("post_overflow", 32'(overflow), 32'd0);
        checkOutput("post_drop", 32'(drop_cnt), 32'd0);
        grfEvent(32'h7000, 5'd7, 32'hCAFE, 1'b0);
        checkOutput("post_valid", 32'(tr_valid), 32'd1);
        checkOutput("post_pc", tr_pc, 32'h7000);
        checkOutput("post_data", tr_data, 32'hCAFE);
        idleCycles(2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparedCount, mismatchCount);
        $finish;
    end

endmodule
